// File: rtl/gray_to_rgb565_pkg.sv
// Shared constants, frame FSM encoding and RGB565 packing for the gray-to-RGB565 output stage.
package gray_to_rgb565_pkg;

    localparam logic [1:0] MODE_GRAY = 2'd0;
    localparam logic [1:0] MODE_HEAT = 2'd1;
    localparam logic [1:0] MODE_BIN  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    localparam int PIPE_LAT = 3;

    typedef enum logic {
        WAIT_FRM = 1'b0,
        RUN      = 1'b1
    } frm_state_t;

    function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/gray_to_rgb565_if.sv
// Pixel/sync bus between the gray processing chain, the colour mapper and the VGA driver.
interface gray_to_rgb565_if;

    // No valid/ready: one pixel per vga_clk, never stalled; syncs travel with their pixel.
    logic [7:0]  din;
    logic        hsync;
    logic        vsync;
    logic [1:0]  mode_in;
    logic [7:0]  thresh_in;
    logic [15:0] dout;
    logic        RGB_HSYNC_OUT;
    logic        RGB_VSYNC_OUT;
    logic [1:0]  mode_act;

    modport master (
        output din, hsync, vsync, mode_in, thresh_in,
        input  dout, RGB_HSYNC_OUT, RGB_VSYNC_OUT, mode_act
    );

    modport slave (
        input  din, hsync, vsync, mode_in, thresh_in,
        output dout, RGB_HSYNC_OUT, RGB_VSYNC_OUT, mode_act
    );

endinterface

// File: rtl/gray_to_rgb565_heat_lut_seg.sv
// Heat pseudo-colour map: blue -> cyan -> green -> yellow -> red across the four gray segments.
module heat_lut_seg (
    input  logic [1:0] seg,
    input  logic [5:0] off,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic [7:0] o4;
    assign o4 = {off, 2'b00};

    always_comb begin
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        unique case (seg)
            2'd0: begin g = o4;    b = 8'hFF;      end
            2'd1: begin g = 8'hFF; b = 8'hFF - o4; end
            2'd2: begin r = o4;    g = 8'hFF;      end
            2'd3: begin r = 8'hFF; g = 8'hFF - o4; end
            default: ;
        endcase
    end

endmodule

// File: rtl/gray_to_rgb565.sv
// 3-stage gray -> RGB565 colour mapper with frame-synchronous mode/threshold shadows.
module gray_to_rgb565
    import gray_to_rgb565_pkg::*;
#(
    parameter logic [1:0] DEF_MODE   = 2'd0,
    parameter logic [7:0] DEF_THRESH = 8'd128,
    parameter logic       VS_POL     = 1'b1
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    gray_to_rgb565_if.slave  bus,
    output frm_state_t       state_dbg
);

    logic [7:0]  s1_pix;
    logic [2:0]  hs_sr;
    logic [2:0]  vs_sr;
    logic [7:0]  s2_r, s2_g, s2_b;
    logic [7:0]  map_r, map_g, map_b;
    logic [7:0]  heat_r, heat_g, heat_b;
    logic [15:0] dout_q;
    logic [1:0]  mode_act_q;
    logic [7:0]  thresh_act;
    logic        frame_edge;
    logic        out_en;
    frm_state_t  state, state_nxt;

    // vs_sr[0] is the S1-registered vsync; the edge is seen one cycle after the pixel enters S1.
    assign frame_edge = (vs_sr[0] == VS_POL) && (vs_sr[1] != VS_POL);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= WAIT_FRM;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_en    = 1'b0;
        unique case (state)
            WAIT_FRM: if (frame_edge) state_nxt = RUN;
            RUN:      out_en = 1'b1;
            default:  state_nxt = WAIT_FRM;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_act_q <= DEF_MODE;
            thresh_act <= DEF_THRESH;
        end else if (frame_edge) begin
            mode_act_q <= bus.mode_in;
            thresh_act <= bus.thresh_in;
        end
    end

    heat_lut_seg u_heat (
        .seg (s1_pix[7:6]),
        .off (s1_pix[5:0]),
        .r   (heat_r),
        .g   (heat_g),
        .b   (heat_b)
    );

    always_comb begin
        map_r = s1_pix;
        map_g = s1_pix;
        map_b = s1_pix;
        unique case (mode_act_q)
            MODE_GRAY: ;
            MODE_HEAT: begin map_r = heat_r; map_g = heat_g; map_b = heat_b; end
            MODE_BIN: begin
                map_r = (s1_pix >= thresh_act) ? 8'hFF : 8'h00;
                map_g = map_r;
                map_b = map_r;
            end
            MODE_INV: begin map_r = ~s1_pix; map_g = ~s1_pix; map_b = ~s1_pix; end
            default: ;
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_pix <= 8'h00;
            hs_sr  <= 3'b000;
            vs_sr  <= 3'b000;
            s2_r   <= 8'h00;
            s2_g   <= 8'h00;
            s2_b   <= 8'h00;
            dout_q <= 16'h0000;
        end else begin
            s1_pix <= bus.din;
            hs_sr  <= {hs_sr[1:0], bus.hsync};
            vs_sr  <= {vs_sr[1:0], bus.vsync};
            s2_r   <= map_r;
            s2_g   <= map_g;
            s2_b   <= map_b;
            dout_q <= out_en ? pack565(s2_r, s2_g, s2_b) : 16'h0000;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.RGB_HSYNC_OUT = hs_sr[2];
    assign bus.RGB_VSYNC_OUT = vs_sr[2];
    assign bus.mode_act      = mode_act_q;

endmodule

// File: tb/tb_gray_to_rgb565.sv
// Bench for gray_to_rgb565: directed steps plus random frames against a frame-level colour-map model.
module tb_gray_to_rgb565;
  import gray_to_rgb565_pkg::*;

  localparam logic [1:0] DEF_MODE   = 2'd0;
  localparam logic [7:0] DEF_THRESH = 8'd128;

  // clock / reset
  logic vga_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #20 vga_clk = ~vga_clk;

  gray_to_rgb565_if bus ();
  frm_state_t state_dbg;

  gray_to_rgb565 #(
    .DEF_MODE   (DEF_MODE),
    .DEF_THRESH (DEF_THRESH),
    .VS_POL     (1'b1)
  ) dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [15:0] exp_q[$];
  logic        hs_q[$];
  logic        vs_q[$];

  // reference model state: frame-level view of the active map
  logic       m_run;
  logic       m_pend;
  logic       m_prev_vs;
  logic [1:0] m_mode;
  logic [7:0] m_thresh;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] map_pix(input logic [1:0] mode, input logic [7:0] thr,
                                          input logic [7:0] p);
    int r, g, b, v, o4;
    v = int'(p);
    r = v; g = v; b = v;
    case (mode)
      MODE_INV: begin r = 255 - v; g = r; b = r; end
      MODE_BIN: begin r = (v >= int'(thr)) ? 255 : 0; g = r; b = r; end
      MODE_HEAT: begin
        o4 = (v % 64) * 4;
        case (v / 64)
          0:       begin r = 0;   g = o4;       b = 255;      end
          1:       begin r = 0;   g = 255;      b = 255 - o4; end
          2:       begin r = o4;  g = 255;      b = 0;        end
          default: begin r = 255; g = 255 - o4; b = 0;        end
        endcase
      end
      default: ;
    endcase
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hs_q.delete();
    vs_q.delete();
    m_run = 1'b0;
    m_pend = 1'b0;
    m_prev_vs = 1'b0;
    m_mode = DEF_MODE;
    m_thresh = DEF_THRESH;
  endtask

  // driver: one pixel per clock, then check the pixel that left the pipeline
  task automatic step(input logic [7:0] d, input logic hs, input logic vs);
    logic [15:0] e;
    logic [15:0] eo;
    logic        eh, ev;
    bus.din = d;
    bus.hsync = hs;
    bus.vsync = vs;
    if (vs && !m_prev_vs) begin
      m_run = 1'b1;
      m_pend = 1'b1;
    end else if (m_pend) begin
      m_mode = bus.mode_in;
      m_thresh = bus.thresh_in;
      m_pend = 1'b0;
    end
    m_prev_vs = vs;
    e = m_run ? map_pix(m_mode, m_thresh, d) : 16'h0000;
    exp_q.push_back(e);
    hs_q.push_back(hs);
    vs_q.push_back(vs);
    @(posedge vga_clk);
    #1;
    chk("mode_act", {14'd0, bus.mode_act}, {14'd0, m_mode});
    if (exp_q.size() == PIPE_LAT) begin
      eo = exp_q.pop_front();
      eh = hs_q.pop_front();
      ev = vs_q.pop_front();
      chk("dout", bus.dout, eo);
      chk("hsync_out", {15'd0, bus.RGB_HSYNC_OUT}, {15'd0, eh});
      chk("vsync_out", {15'd0, bus.RGB_VSYNC_OUT}, {15'd0, ev});
    end
  endtask

  task automatic vs_edge();
    step(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    step(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    step(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++)
      step(8'($urandom_range(0, 255)), (i % 16) < 2, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, bus.dout, 16'h0000);
    chk({tag, "_hs"}, {15'd0, bus.RGB_HSYNC_OUT}, 16'h0000);
    chk({tag, "_vs"}, {15'd0, bus.RGB_VSYNC_OUT}, 16'h0000);
    chk({tag, "_mode"}, {14'd0, bus.mode_act}, {14'd0, DEF_MODE});
  endtask

  initial begin
    bus.din = 8'h00;
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    bus.mode_in = MODE_GRAY;
    bus.thresh_in = 8'd128;
    model_reset();

    // power-on reset
    repeat (3) @(posedge vga_clk);
    #1;
    check_reset_outputs("por");
    sys_rst_n = 1'b1;

    // before the first frame edge: black output, syncs still delayed by 3
    for (int i = 0; i < 10; i++) step(8'($urandom_range(1, 255)), i == 4, 1'b0);

    // gray replicate
    bus.mode_in = MODE_GRAY;
    vs_edge();
    step(8'hFF, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    rand_pixels(8);

    // heat, every segment boundary
    bus.mode_in = MODE_HEAT;
    vs_edge();
    step(8'd0, 1'b0, 1'b0);
    step(8'd64, 1'b0, 1'b0);
    step(8'd128, 1'b0, 1'b0);
    step(8'd192, 1'b0, 1'b0);
    step(8'd255, 1'b0, 1'b0);
    step(8'd63, 1'b0, 1'b0);
    step(8'd191, 1'b0, 1'b0);
    rand_pixels(8);

    // binary around the threshold
    bus.mode_in = MODE_BIN;
    bus.thresh_in = 8'd128;
    vs_edge();
    step(8'd127, 1'b0, 1'b0);
    step(8'd128, 1'b0, 1'b0);
    step(8'd129, 1'b0, 1'b0);
    rand_pixels(6);

    // inverted
    bus.mode_in = MODE_INV;
    vs_edge();
    step(8'h00, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    rand_pixels(6);

    // mid-frame mode request is deferred to the next frame edge
    bus.mode_in = MODE_GRAY;
    vs_edge();
    rand_pixels(5);
    bus.mode_in = MODE_HEAT;
    bus.thresh_in = 8'($urandom_range(0, 255));
    rand_pixels(10);
    vs_edge();
    rand_pixels(6);

    // random frames, random map and threshold each frame
    for (int f = 0; f < 8; f++) begin
      bus.mode_in = 2'($urandom_range(0, 3));
      bus.thresh_in = 8'($urandom_range(0, 255));
      vs_edge();
      rand_pixels(40);
      bus.mode_in = 2'($urandom_range(0, 3));
      bus.thresh_in = 8'($urandom_range(0, 255));
      rand_pixels(8);
    end

    // reset during active video with a non-default map and syncs in flight
    bus.mode_in = MODE_INV;
    vs_edge();
    step(8'h11, 1'b1, 1'b0);
    step(8'h22, 1'b1, 1'b0);
    step(8'h33, 1'b1, 1'b0);
    #5;
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    rand_pixels(12);
    bus.mode_in = MODE_HEAT;
    vs_edge();
    rand_pixels(12);

    for (int i = 0; i < PIPE_LAT; i++) step(8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
